dmem_mmio: RTL and testbench

Data-memory responder for the single-cycle CPU's data port. It answers every load and store the CPU issues, and it owns the data RAM plus a small memory-mapped register block: timer, compare, status, and GPIO.
- Reads are combinational, so the CPU gets load data in the same cycle.
- Writes commit on the rising clock edge.
- A debug read port mirrors the CPU's register-file debug port, for board-level inspection.

---
 rtl/dmem_mmio.sv | 140 ++++++++++++++
 tb/tb_dmem_mmio.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-memory responder: word-addressed RAM plus a memory-mapped timer/compare/status/GPIO
// block. Loads are combinational; stores and timer updates commit on the rising clock edge.
module dmem_mmio #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  input  logic          we_i,
  output logic [31:0]   rdata_o,
  output logic [31:0]   gpio_out_o,
  output logic          irq_o,
  output logic          bus_err_o,
  input  logic [AW-1:0] dbg_sel_i,
  output logic [31:0]   dbg_data_o
);

  localparam logic [7:0] OffCnt  = 8'h00;
  localparam logic [7:0] OffCmp  = 8'h04;
  localparam logic [7:0] OffCtrl = 8'h08;
  localparam logic [7:0] OffStat = 8'h0C;
  localparam logic [7:0] OffGpio = 8'h10;

  logic [31:0] ram_q [DEPTH];
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        stat_q, stat_d;
  logic [31:0] gpio_q, gpio_d;
  logic        bus_err_q, bus_err_d;

  logic          is_ram;
  logic          is_mmio;
  logic [AW-1:0] word_idx;
  logic [7:0]    off;
  logic          ram_we;
  logic          mmio_we;
  logic          ctrl_en;
  logic          ctrl_clr;
  logic          ctrl_irq_en;
  logic          match;

  // Word access only: byte-lane bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

  assign is_ram   = (addr_i[31:AW+2] == '0);
  assign is_mmio  = (addr_i[31:8] == 24'hFF_FFFF);
  assign word_idx = addr_i[AW+1:2];
  assign off      = addr_i[7:0];
  assign ram_we   = we_i & is_ram;
  assign mmio_we  = we_i & is_mmio;

  assign ctrl_en     = ctrl_q[0];
  assign ctrl_clr    = ctrl_q[1];
  assign ctrl_irq_en = ctrl_q[2];
  assign match       = ctrl_en & (cnt_q == cmp_q);

  always_comb begin
    rdata_o = '0;
    if (is_ram) begin
      rdata_o = ram_q[word_idx];
    end else if (is_mmio) begin
      case (off)
        OffCnt:  rdata_o = cnt_q;
        OffCmp:  rdata_o = cmp_q;
        OffCtrl: rdata_o = {29'd0, ctrl_q};
        OffStat: rdata_o = {31'd0, stat_q};
        OffGpio: rdata_o = gpio_q;
        default: rdata_o = '0;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    stat_d    = stat_q;
    gpio_d    = gpio_q;
    bus_err_d = bus_err_q | ~(is_ram | is_mmio);

    if (ctrl_en) begin
      cnt_d = (match && ctrl_clr) ? 32'd0 : cnt_q + 32'd1;
    end

    // CPU writes override the timer update; compare already used the pre-write count.
    if (mmio_we) begin
      case (off)
        OffCnt:  cnt_d  = wdata_i;
        OffCmp:  cmp_d  = wdata_i;
        OffCtrl: ctrl_d = wdata_i[2:0];
        OffStat: if (wdata_i[0]) stat_d = 1'b0;
        OffGpio: gpio_d = wdata_i;
        default: ;
      endcase
    end

    // A new match beats a same-cycle W1C.
    if (match) begin
      stat_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      cmp_q     <= '0;
      ctrl_q    <= '0;
      stat_q    <= 1'b0;
      gpio_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      ctrl_q    <= ctrl_d;
      stat_q    <= stat_d;
      gpio_q    <= gpio_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ram_q[i] <= '0;
      end
    end else if (ram_we) begin
      ram_q[word_idx] <= wdata_i;
    end
  end

  assign gpio_out_o = gpio_q;
  assign irq_o      = stat_q & ctrl_irq_en;
  assign bus_err_o  = bus_err_q;
  assign dbg_data_o = ram_q[dbg_sel_i];

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, same-cycle read/write, timer, collisions,
// GPIO, bus error and asynchronous reset.
module tb_dmem_mmio;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;

  localparam logic [31:0] ACnt  = 32'hFFFF_FF00;
  localparam logic [31:0] ACmp  = 32'hFFFF_FF04;
  localparam logic [31:0] ACtrl = 32'hFFFF_FF08;
  localparam logic [31:0] AStat = 32'hFFFF_FF0C;
  localparam logic [31:0] AGpio = 32'hFFFF_FF10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic          we = 1'b0;
  logic [AW-1:0] dbg_sel = '0;
  logic [31:0]   rdata;
  logic [31:0]   gpio_out;
  logic          irq;
  logic          bus_err;
  logic [31:0]   dbg_data;

  int checks = 0;
  int failures = 0;

  dmem_mmio #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .we_i       (we),
    .rdata_o    (rdata),
    .gpio_out_o (gpio_out),
    .irq_o      (irq),
    .bus_err_o  (bus_err),
    .dbg_sel_i  (dbg_sel),
    .dbg_data_o (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    rd(32'h0000_0040, v);
    checks++; if (v !== 32'h0) begin failures++;
      $display("FAIL reset_rdata got=%h exp=%h", v, 32'h0); end
    checks++; if (gpio_out !== 32'h0) begin failures++;
      $display("FAIL reset_gpio got=%h exp=%h", gpio_out, 32'h0); end
    checks++; if (irq !== 1'b0) begin failures++;
      $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (bus_err !== 1'b0) begin failures++;
      $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, v);
    checks++; if (v !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL ram_load got=%h exp=%h", v, 32'hDEAD_BEEF); end
    dbg_sel = 7'd4;
    #1;
    checks++; if (dbg_data !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL ram_dbg got=%h exp=%h", dbg_data, 32'hDEAD_BEEF); end
    rd(32'h0000_0013, v);
    checks++; if (v !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL ram_byte_ign got=%h exp=%h", v, 32'hDEAD_BEEF); end
    rd(32'h0000_0014, v);
    checks++; if (v !== 32'h0) begin failures++;
      $display("FAIL ram_neighbour got=%h exp=%h", v, 32'h0); end
  endtask

  task automatic test_same_cycle();
    wr(32'h0000_0008, 32'd3);
    addr  = 32'h0000_0008;
    wdata = 32'd5;
    we    = 1'b1;
    #1;
    checks++; if (rdata !== 32'd3) begin failures++;
      $display("FAIL rw_old got=%h exp=%h", rdata, 32'd3); end
    @(posedge clk);
    #1;
    we = 1'b0;
    checks++; if (rdata !== 32'd5) begin failures++;
      $display("FAIL rw_new got=%h exp=%h", rdata, 32'd5); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    logic [31:0] exp_cnt [3];
    exp_cnt[0] = 32'd1; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd3;
    wr(ACmp, 32'd3);
    wr(ACtrl, 32'hFFFF_FFF7);
    rd(ACtrl, v);
    checks++; if (v !== 32'h7) begin failures++;
      $display("FAIL ctrl_mask got=%h exp=%h", v, 32'h7); end
    rd(ACnt, v);
    checks++; if (v !== 32'd0) begin failures++;
      $display("FAIL tmr_start got=%h exp=%h", v, 32'd0); end
    for (int i = 0; i < 3; i++) begin
      step();
      rd(ACnt, v);
      checks++; if (v !== exp_cnt[i] || irq !== 1'b0) begin failures++;
        $display("FAIL tmr_count%0d got=%h/%b exp=%h/0", i, v, irq, exp_cnt[i]); end
    end
    step();
    rd(ACnt, v);
    checks++; if (v !== 32'd0) begin failures++;
      $display("FAIL tmr_clear got=%h exp=%h", v, 32'd0); end
    rd(AStat, v);
    checks++; if (v !== 32'd1 || irq !== 1'b1) begin failures++;
      $display("FAIL tmr_match got=%h/%b exp=1/1", v, irq); end
    wr(AStat, 32'd1);
    rd(AStat, v);
    checks++; if (v !== 32'd0 || irq !== 1'b0) begin failures++;
      $display("FAIL tmr_w1c got=%h/%b exp=0/0", v, irq); end
    step();
    step();
    checks++; if (irq !== 1'b0) begin failures++;
      $display("FAIL tmr_premature got=%b exp=0", irq); end
    step();
    checks++; if (irq !== 1'b1) begin failures++;
      $display("FAIL tmr_rematch got=%b exp=1", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    step(); step(); step();
    wr(AStat, 32'd1);
    rd(AStat, v);
    checks++; if (v !== 32'd1) begin failures++;
      $display("FAIL col_w1c_set got=%h exp=%h", v, 32'd1); end
    rd(ACnt, v);
    checks++; if (v !== 32'd0) begin failures++;
      $display("FAIL col_clear got=%h exp=%h", v, 32'd0); end
    wr(ACnt, 32'h100);
    rd(ACnt, v);
    checks++; if (v !== 32'h100) begin failures++;
      $display("FAIL col_cnt_wr got=%h exp=%h", v, 32'h100); end
    wr(AStat, 32'd1);
    wr(ACnt, 32'd3);
    wr(ACnt, 32'h50);
    rd(AStat, v);
    checks++; if (v !== 32'd1) begin failures++;
      $display("FAIL col_prewrite_match got=%h exp=%h", v, 32'd1); end
    rd(ACnt, v);
    checks++; if (v !== 32'h50) begin failures++;
      $display("FAIL col_prewrite_cnt got=%h exp=%h", v, 32'h50); end
    wr(ACtrl, 32'd0);
    rd(ACnt, v);
    checks++; if (v !== 32'h51) begin failures++;
      $display("FAIL ctrl_delay got=%h exp=%h", v, 32'h51); end
    step();
    rd(ACnt, v);
    checks++; if (v !== 32'h51) begin failures++;
      $display("FAIL ctrl_hold got=%h exp=%h", v, 32'h51); end
  endtask

  task automatic test_gpio();
    logic [31:0] v;
    wr(AGpio, 32'h1234_5678);
    checks++; if (gpio_out !== 32'h1234_5678) begin failures++;
      $display("FAIL gpio_out got=%h exp=%h", gpio_out, 32'h1234_5678); end
    rd(AGpio, v);
    checks++; if (v !== 32'h1234_5678) begin failures++;
      $display("FAIL gpio_rd got=%h exp=%h", v, 32'h1234_5678); end
    wr(32'hFFFF_FF14, 32'hFFFF_FFFF);
    rd(32'hFFFF_FF14, v);
    checks++; if (v !== 32'h0 || bus_err !== 1'b0) begin failures++;
      $display("FAIL mmio_hole got=%h/%b exp=0/0", v, bus_err); end
  endtask

  task automatic test_bus_err();
    logic [31:0] v;
    rd(32'h8000_0000, v);
    checks++; if (v !== 32'h0 || bus_err !== 1'b0) begin failures++;
      $display("FAIL berr_pre got=%h/%b exp=0/0", v, bus_err); end
    step();
    addr = 32'h0;
    checks++; if (bus_err !== 1'b1) begin failures++;
      $display("FAIL berr_set got=%b exp=1", bus_err); end
    wr(32'h0000_0010, 32'h0BAD_F00D);
    rd(32'h0000_0010, v);
    step();
    checks++; if (bus_err !== 1'b1 || v !== 32'h0BAD_F00D) begin failures++;
      $display("FAIL berr_sticky got=%b/%h exp=1/0badf00d", bus_err, v); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_err !== 1'b0) begin failures++;
      $display("FAIL berr_reset got=%b exp=0", bus_err); end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    wr(AGpio, 32'hA5);
    wr(ACtrl, 32'd5);
    step();
    checks++; if (irq !== 1'b1 || gpio_out !== 32'hA5) begin failures++;
      $display("FAIL ar_pre got=%b/%h exp=1/a5", irq, gpio_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (irq !== 1'b0 || gpio_out !== 32'h0) begin failures++;
      $display("FAIL ar_out got=%b/%h exp=0/0", irq, gpio_out); end
    rd(ACnt, v);
    checks++; if (v !== 32'h0) begin failures++;
      $display("FAIL ar_cnt got=%h exp=%h", v, 32'h0); end
    addr  = 32'h0000_0020;
    wdata = 32'h1234;
    we    = 1'b1;
    step();
    we = 1'b0;
    #2;
    rst_n = 1'b1;
    dbg_sel = 7'd8;
    #1;
    checks++; if (dbg_data !== 32'h0) begin failures++;
      $display("FAIL ar_store_dropped got=%h exp=%h", dbg_data, 32'h0); end
    rd(32'h0000_0010, v);
    checks++; if (v !== 32'h0) begin failures++;
      $display("FAIL ar_ram_clr got=%h exp=%h", v, 32'h0); end
    wr(32'h0000_0020, 32'h1234);
    checks++; if (dbg_data !== 32'h1234) begin failures++;
      $display("FAIL ar_first_wr got=%h exp=%h", dbg_data, 32'h1234); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_same_cycle();
    test_timer();
    test_collision();
    test_gpio();
    test_bus_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
